// File: rtl/umi_write_arbiter.sv
// -----------------------------------------------------------------------------
// umi_write_arbiter
//   Shares one UMI write sink (the UMI-to-AXI write bridge) between N UMI
//   requesters. Round-robin arbitration grants one whole packet at a time. The
//   packet is captured into a register and held until the sink pulses
//   out_ready. After every completed transfer, out_valid is held low for one
//   GAP cycle so the sink can leave its in-progress state.
//
// Ports
//   clk          clock
//   rst          synchronous active-high reset
//   in_packet    N*DW  requester i packet at [i*DW +: DW]
//   in_valid     N     requester i has a packet
//   in_ready     N     one-cycle accept pulse to the winning requester (combinational)
//   out_packet   DW    buffered packet to the sink
//   out_valid    1     buffered packet valid
//   out_ready    1     sink completion pulse, honoured only while BUSY
//   grant_id     IW    index of the requester whose packet is buffered
//   busy         1     high in BUSY and GAP
//   timeout_err  1     sticky flag: BUSY lasted TIMEOUT cycles (0 disables)
// -----------------------------------------------------------------------------
module umi_write_arbiter #(
    parameter int N       = 4,
    parameter int DW      = 256,
    parameter int TIMEOUT = 1024,
    localparam int IW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*DW-1:0] in_packet,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    output logic [DW-1:0]   out_packet,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [IW-1:0]   grant_id,
    output logic            busy,
    output logic            timeout_err
);

    // The counter only has to reach TIMEOUT, after which it saturates.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        GAP
    } state_t;

    state_t          state;
    logic [IW-1:0]   rr_ptr;
    logic [CW-1:0]   wait_cnt;

    logic [2*N-1:0]  rotated;
    logic            found;
    int              offset;
    logic [IW-1:0]   win;
    logic [IW-1:0]   next_ptr;
    logic [DW-1:0]   win_packet;

    // Winner search: rotate the request vector so rr_ptr sits at bit 0. The
    // lowest set bit of the rotated vector is then the first requester found
    // walking rr_ptr, rr_ptr+1, ... modulo N.
    // NOTE: combinational blocks use blocking assignments so later statements
    // see the values computed earlier in the same pass; sequential state
    // further down uses non-blocking assignments only.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        rotated    = {in_valid, in_valid} >> rr_ptr;
        found      = 1'b0;
        offset     = 0;
        win        = '0;
        next_ptr   = '0;
        win_packet = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                found  = 1'b1;
                offset = k;
            end
        end
        win      = IW'((int'(rr_ptr) + offset) % N);
        next_ptr = IW'((int'(win) + 1) % N);
        for (int i = 0; i < N; i++) begin
            if (win == IW'(i)) begin
                win_packet = in_packet[i*DW +: DW];
            end
        end
    end

    // The accept pulse is combinational so the requester sees it in the same
    // cycle the capture edge happens; suppressed while rst is asserted.
    always_comb begin
        in_ready = '0;
        if (!rst && state == IDLE && found) begin
            in_ready = N'(1) << win;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the packet buffer is reset too, so a discarded packet can
            // never reappear on out_packet after reset.
            state       <= IDLE;
            rr_ptr      <= '0;
            wait_cnt    <= '0;
            out_packet  <= '0;
            out_valid   <= 1'b0;
            grant_id    <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        out_packet <= win_packet;
                        grant_id   <= win;
                        rr_ptr     <= next_ptr;
                        out_valid  <= 1'b1;
                        busy       <= 1'b1;
                        wait_cnt   <= '0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (wait_cnt != CW'(TIMEOUT)) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                    // The packet is kept on timeout; the flag only reports it.
                    if (TIMEOUT != 0 && int'(wait_cnt) + 1 >= TIMEOUT) begin
                        timeout_err <= 1'b1;
                    end
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= GAP;
                    end
                end
                GAP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_umi_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_umi_write_arbiter
//   Self-checking bench for umi_write_arbiter (N=4, DW=32, TIMEOUT=8).
//   A table of hand-derived vectors, hand-written corner sequences and a
//   randomized run, all compared every cycle against a transaction-level
//   reference model of the arbiter.
// -----------------------------------------------------------------------------
module tb_umi_write_arbiter;

    localparam int N       = 4;
    localparam int DW      = 32;
    localparam int TIMEOUT = 8;
    localparam int IW      = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*DW-1:0] in_packet;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [DW-1:0]   out_packet;
    logic            out_valid;
    logic            out_ready;
    logic [IW-1:0]   grant_id;
    logic            busy;
    logic            timeout_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    umi_write_arbiter #(.N(N), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_packet   (in_packet),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_packet  (out_packet),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    // ---------------------------------------------------------------- checking
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------------------------------------------------- reference model
    // Holds "a packet is parked at the sink", "a gap cycle is pending", the
    // next requester to start the search from and how long the sink has waited.
    bit            m_holding;
    bit            m_gap;
    bit            m_err;
    int            m_ptr;
    int            m_waited;
    int            m_gid;
    logic [DW-1:0] m_pkt;

    function automatic int pick(input logic [N-1:0] v, input int start);
        for (int k = 0; k < N; k++) begin
            if (v[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_holding = 0;
        m_gap     = 0;
        m_err     = 0;
        m_ptr     = 0;
        m_waited  = 0;
        m_gid     = 0;
        m_pkt     = '0;
    endtask

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r;
        int w;
        r = '0;
        if (!rst && !m_holding && !m_gap) begin
            w = pick(in_valid, m_ptr);
            if (w >= 0) r[w] = 1'b1;
        end
        return r;
    endfunction

    task automatic model_step();
        int w;
        if (rst) begin
            model_reset();
        end else if (m_gap) begin
            m_gap = 0;
        end else if (m_holding) begin
            m_waited++;
            if (m_waited >= TIMEOUT) m_err = 1;
            if (out_ready) begin
                m_holding = 0;
                m_gap     = 1;
            end
        end else begin
            w = pick(in_valid, m_ptr);
            if (w >= 0) begin
                m_pkt     = in_packet[w*DW +: DW];
                m_gid     = w;
                m_ptr     = (w + 1) % N;
                m_holding = 1;
                m_waited  = 0;
            end
        end
    endtask

    // ------------------------------------------------------------ vector table
    typedef struct packed {
        logic [N-1:0]  iv;
        logic          ordy;
        logic [N-1:0]  ir;
        logic          ov;
        logic [IW-1:0] gid;
        logic          bsy;
    } vec_t;

    function automatic vec_t mk(input logic [N-1:0] iv, input logic ordy, input logic [N-1:0] ir,
                                input logic ov, input logic [IW-1:0] gid, input logic bsy);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.ir = ir; v.ov = ov; v.gid = gid; v.bsy = bsy;
        return v;
    endfunction

    // One clock cycle: outputs compared mid-cycle on the falling edge against
    // the model (and optionally a table row), then the model advances with
    // the inputs of this cycle. Returns 1 time unit after the rising edge.
    task automatic cycle(input bit use_row, input vec_t row);
        logic [N-1:0] e_ir;
        @(negedge clk);
        e_ir = model_ready();
        check("in_ready",    64'(in_ready),    64'(e_ir));
        check("out_valid",   64'(out_valid),   64'(m_holding));
        check("out_packet",  64'(out_packet),  64'(m_pkt));
        check("grant_id",    64'(grant_id),    64'(m_gid));
        check("busy",        64'(busy),        64'(m_holding | m_gap));
        check("timeout_err", 64'(timeout_err), 64'(m_err));
        if (use_row) begin
            check("tbl in_ready",  64'(in_ready),  64'(row.ir));
            check("tbl out_valid", 64'(out_valid), 64'(row.ov));
            check("tbl grant_id",  64'(grant_id),  64'(row.gid));
            check("tbl busy",      64'(busy),      64'(row.bsy));
        end
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic tick();
        cycle(1'b0, '0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = '0;
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "watchdog expired");
    end

    localparam logic [N*DW-1:0] FIXED_PKTS = {32'h3C3C3C3C, 32'hA5A5A5A5, 32'h11111111, 32'h000000C0};

    initial begin
        vec_t tbl[22];

        // ---- initial reset; outputs are unknown before it
        rst       = 1'b1;
        in_valid  = '0;
        out_ready = 1'b0;
        in_packet = FIXED_PKTS;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check("reset out_valid",   64'(out_valid),   64'd0);
        check("reset busy",        64'(busy),        64'd0);
        check("reset grant_id",    64'(grant_id),    64'd0);
        check("reset out_packet",  64'(out_packet),  64'd0);
        check("reset timeout_err", 64'(timeout_err), 64'd0);
        in_valid = 4'b1111;
        #1;
        check("reset in_ready", 64'(in_ready), 64'd0);
        in_valid = '0;
        rst = 1'b0;

        // ---- table: single requester 2, then all four held with the sink
        // completing on the first valid cycle (back-to-back, 3 cycles/packet)
        //              iv     ordy ir     ov gid bsy
        tbl[0]  = mk(4'b0100, 0, 4'b0100, 0, 0, 0);
        tbl[1]  = mk(4'b0000, 0, 4'b0000, 1, 2, 1);
        tbl[2]  = mk(4'b0000, 0, 4'b0000, 1, 2, 1);
        tbl[3]  = mk(4'b0000, 1, 4'b0000, 1, 2, 1);
        tbl[4]  = mk(4'b1111, 0, 4'b0000, 0, 2, 1);  // GAP ignores requests
        tbl[5]  = mk(4'b1111, 0, 4'b1000, 0, 2, 0);  // rr_ptr advanced to 3
        tbl[6]  = mk(4'b1111, 1, 4'b0000, 1, 3, 1);
        tbl[7]  = mk(4'b1111, 1, 4'b0000, 0, 3, 1);  // out_ready in GAP ignored
        tbl[8]  = mk(4'b1111, 1, 4'b0001, 0, 3, 0);  // accept 2 cycles after out_ready
        tbl[9]  = mk(4'b1111, 1, 4'b0000, 1, 0, 1);
        tbl[10] = mk(4'b1111, 0, 4'b0000, 0, 0, 1);
        tbl[11] = mk(4'b1111, 0, 4'b0010, 0, 0, 0);
        tbl[12] = mk(4'b1111, 1, 4'b0000, 1, 1, 1);
        tbl[13] = mk(4'b1111, 0, 4'b0000, 0, 1, 1);
        tbl[14] = mk(4'b1111, 0, 4'b0100, 0, 1, 0);
        tbl[15] = mk(4'b1111, 1, 4'b0000, 1, 2, 1);
        tbl[16] = mk(4'b1111, 0, 4'b0000, 0, 2, 1);
        tbl[17] = mk(4'b1111, 0, 4'b1000, 0, 2, 0);
        tbl[18] = mk(4'b1111, 1, 4'b0000, 1, 3, 1);
        tbl[19] = mk(4'b0000, 0, 4'b0000, 0, 3, 1);
        tbl[20] = mk(4'b0000, 0, 4'b0000, 0, 3, 0);
        tbl[21] = mk(4'b0000, 1, 4'b0000, 0, 3, 0);  // out_ready in IDLE ignored
        for (int i = 0; i < 22; i++) begin
            in_valid  = tbl[i].iv;
            out_ready = tbl[i].ordy;
            cycle(1'b1, tbl[i]);
            if (i == 0) check("t1 out_packet", 64'(out_packet), 64'hA5A5A5A5);
        end

        // ---- rr_ptr=3 with requests 0 and 2; requester 1 raised during 2's transfer
        do_reset();
        in_valid = 4'b0100; tick();                  // grant 2, rr_ptr -> 3
        in_valid = 4'b0000; out_ready = 1; tick();
        out_ready = 0; tick();                       // GAP
        in_valid = 4'b0101; tick();
        check("t3 first grant", 64'(grant_id), 64'd0);
        in_valid = 4'b0100; out_ready = 1; tick();
        out_ready = 0; tick();
        tick();
        check("t3 second grant", 64'(grant_id), 64'd2);
        in_valid = 4'b0010; out_ready = 1; tick();
        out_ready = 0; tick();
        tick();
        check("t3 third grant", 64'(grant_id), 64'd1);
        in_valid = 4'b0000; out_ready = 1; tick();
        out_ready = 0; tick();

        // ---- timeout: sink silent for TIMEOUT cycles, then completes late
        in_valid = 4'b0001; tick();                  // rr_ptr is 2 -> grant 0
        in_valid = 4'b0000;
        repeat (TIMEOUT - 1) tick();
        check("t5 err before limit", 64'(timeout_err), 64'd0);
        tick();
        check("t5 err at limit", 64'(timeout_err), 64'd1);
        check("t5 valid kept", 64'(out_valid), 64'd1);
        repeat (3) tick();
        out_ready = 1; tick();
        check("t5 late completion", 64'(out_valid), 64'd0);
        out_ready = 0; tick();
        check("t5 err sticky", 64'(timeout_err), 64'd1);

        // ---- reset while BUSY clears everything, then serves from rr_ptr=0
        in_valid = 4'b0001; tick();
        in_valid = 4'b0010; rst = 1; tick();
        check("t6 valid after rst", 64'(out_valid), 64'd0);
        check("t6 busy after rst",  64'(busy),      64'd0);
        check("t6 err after rst",   64'(timeout_err), 64'd0);
        check("t6 gid after rst",   64'(grant_id),  64'd0);
        rst = 0; tick();
        check("t6 grant after rst", 64'(grant_id), 64'd1);
        in_valid = 4'b0000; out_ready = 1; tick();
        out_ready = 0; tick();

        // ---- randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            in_packet = {$urandom, $urandom, $urandom, $urandom};
            in_valid  = N'($urandom);
            out_ready = (i < 1500) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 15) == 0);
            rst       = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
